bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master, round-robin arbiter in front of a single external bus.
//   A granted transaction ends either when the external bus acks, or when it
//   has been outstanding for TIMEOUT cycles. A timeout returns ack+err together
//   with zero read data.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_mN_bus_en                  master N request (held until its ack)
//   i_mN_wr_en/_wr_data/_addr/_byte_en   master N transaction fields
//   o_mN_ack, o_mN_err           one-cycle completion / timeout pulses
//   o_mN_rd_data                 read data returned to master N
//   i_ack, i_rd_data             external bus completion and read data
//   o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en   external bus request
//   o_grant                      index of the current or last granted master
module bus_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_bus_en,
  input  logic        i_m0_wr_en,
  input  logic [31:0] i_m0_wr_data,
  input  logic [31:0] i_m0_addr,
  input  logic [3:0]  i_m0_byte_en,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rd_data,
  input  logic        i_m1_bus_en,
  input  logic        i_m1_wr_en,
  input  logic [31:0] i_m1_wr_data,
  input  logic [31:0] i_m1_addr,
  input  logic [3:0]  i_m1_byte_en,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rd_data,
  input  logic        i_ack,
  input  logic [31:0] i_rd_data,
  output logic        o_bus_en,
  output logic        o_wr_en,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_addr,
  output logic [3:0]  o_byte_en,
  output logic        o_grant
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          last_reg, last_next;
  logic [CW-1:0] count_reg, count_next;
  logic          timeout;
  logic          done;

  // Per-master views of the request fields so the mux is a simple index.
  logic [1:0]  req;
  logic        wr_en_arr   [2];
  logic [31:0] wr_data_arr [2];
  logic [31:0] addr_arr    [2];
  logic [3:0]  be_arr      [2];
  logic [1:0]  ack_vec;
  logic [1:0]  err_vec;
  logic [31:0] rd_arr      [2];

  assign req            = {i_m1_bus_en, i_m0_bus_en};
  assign wr_en_arr[0]   = i_m0_wr_en;
  assign wr_en_arr[1]   = i_m1_wr_en;
  assign wr_data_arr[0] = i_m0_wr_data;
  assign wr_data_arr[1] = i_m1_wr_data;
  assign addr_arr[0]    = i_m0_addr;
  assign addr_arr[1]    = i_m1_addr;
  assign be_arr[0]      = i_m0_byte_en;
  assign be_arr[1]      = i_m1_byte_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      last_reg  <= 1'b1;   // master 0 wins the first tie
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    count_next = count_reg;
    timeout    = 1'b0;
    done       = 1'b0;
    o_bus_en   = 1'b0;
    o_wr_en    = 1'b0;
    o_wr_data  = '0;
    o_addr     = '0;
    o_byte_en  = '0;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie, serve whoever was not served last time.
          if (req == 2'b11) grant_next = ~last_reg;
          else              grant_next = req[1];
          last_next  = grant_next;
          count_next = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        o_bus_en  = 1'b1;
        o_wr_en   = wr_en_arr[grant_reg];
        o_wr_data = wr_data_arr[grant_reg];
        o_addr    = addr_arr[grant_reg];
        o_byte_en = be_arr[grant_reg];
        timeout   = (count_reg == LAST_COUNT);
        done      = i_ack | timeout;
        if (done) state_next = IDLE;
        else      count_next = count_reg + CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion responses go only to the granted master. A reset in the same
  // cycle aborts the transaction, so nothing is forwarded then. A real ack
  // beats a coincident timeout, so err needs the ack to be absent.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic mine;
      assign mine        = done & ~i_rst & (grant_reg == 1'(gi));
      assign ack_vec[gi] = mine;
      assign err_vec[gi] = mine & ~i_ack;
      assign rd_arr[gi]  = (mine & i_ack) ? i_rd_data : 32'h0;
    end
  endgenerate

  assign o_m0_ack     = ack_vec[0];
  assign o_m1_ack     = ack_vec[1];
  assign o_m0_err     = err_vec[0];
  assign o_m1_err     = err_vec[1];
  assign o_m0_rd_data = rd_arr[0];
  assign o_m1_rd_data = rd_arr[1];
  assign o_grant      = grant_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed scenarios for bus_arbiter (TIMEOUT=8) followed by a randomized
//   traffic run checked against a transaction-level model of the arbiter.
module tb_bus_arbiter;
  localparam int TIMEOUT = 8;

  logic        i_clk;
  logic        i_rst;
  logic        i_m0_bus_en, i_m0_wr_en, i_m1_bus_en, i_m1_wr_en;
  logic [31:0] i_m0_wr_data, i_m0_addr, i_m1_wr_data, i_m1_addr;
  logic [3:0]  i_m0_byte_en, i_m1_byte_en;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [31:0] o_m0_rd_data, o_m1_rd_data;
  logic        i_ack;
  logic [31:0] i_rd_data;
  logic        o_bus_en, o_wr_en, o_grant;
  logic [31:0] o_wr_data, o_addr;
  logic [3:0]  o_byte_en;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_bus_en(i_m0_bus_en), .i_m0_wr_en(i_m0_wr_en), .i_m0_wr_data(i_m0_wr_data),
    .i_m0_addr(i_m0_addr), .i_m0_byte_en(i_m0_byte_en),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_rd_data(o_m0_rd_data),
    .i_m1_bus_en(i_m1_bus_en), .i_m1_wr_en(i_m1_wr_en), .i_m1_wr_data(i_m1_wr_data),
    .i_m1_addr(i_m1_addr), .i_m1_byte_en(i_m1_byte_en),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_rd_data(o_m1_rd_data),
    .i_ack(i_ack), .i_rd_data(i_rd_data),
    .o_bus_en(o_bus_en), .o_wr_en(o_wr_en), .o_wr_data(o_wr_data),
    .o_addr(o_addr), .o_byte_en(o_byte_en), .o_grant(o_grant)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_m0(input logic en, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    i_m0_bus_en = en; i_m0_wr_en = we; i_m0_addr = a; i_m0_wr_data = d; i_m0_byte_en = be;
  endtask

  task automatic set_m1(input logic en, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    i_m1_bus_en = en; i_m1_wr_en = we; i_m1_addr = a; i_m1_wr_data = d; i_m1_byte_en = be;
  endtask

  task automatic clear_inputs;
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    i_ack = 1'b0;
    i_rd_data = 32'h0;
  endtask

  task automatic do_reset;
    clear_inputs();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset;
    // Reset beats a request and an ack presented at the same edge.
    i_rst = 1'b1;
    set_m0(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    i_ack = 1'b1;
    i_rd_data = 32'h1234;
    tick();
    i_rst = 1'b0;
    clear_inputs();
    #1;
    n_checks++;
    if ({o_bus_en, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_grant} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {o_bus_en, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_grant});
    end
    n_checks++;
    if ({o_wr_en, o_wr_data, o_addr, o_byte_en, o_m0_rd_data, o_m1_rd_data} !== 133'b0) begin
      n_fail++;
      $display("FAIL reset_data: got wr=%b wd=%h a=%h be=%h rd0=%h rd1=%h expected all zero",
               o_wr_en, o_wr_data, o_addr, o_byte_en, o_m0_rd_data, o_m1_rd_data);
    end
    tick();
    n_checks++;
    if (o_bus_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: bus_en got %b expected 0", o_bus_en);
    end
  endtask

  task automatic test_single_read;
    int cnt = 0;
    set_m0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    #1;
    n_checks++;
    if (o_bus_en !== 1'b0) begin
      n_fail++;
      $display("FAIL read_first_cycle: bus_en got %b expected 0", o_bus_en);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin
        i_ack = 1'b1;
        i_rd_data = 32'hDEADBEEF;
      end
      #1;
      if (o_bus_en === 1'b1) cnt++;
      n_checks++;
      if ({o_addr, o_wr_en, o_byte_en, o_grant} !== {32'h100, 1'b0, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL read_bus_fields k=%0d: got a=%h we=%b be=%h g=%b expected a=00000100 we=0 be=f g=0",
                 k, o_addr, o_wr_en, o_byte_en, o_grant);
      end
      n_checks++;
      if ({o_m0_ack, o_m1_ack, o_m0_err, o_m1_err} !== {(k == 3), 3'b000}) begin
        n_fail++;
        $display("FAIL read_ack k=%0d: got %b expected %b", k,
                 {o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, {(k == 3), 3'b000});
      end
    end
    n_checks++;
    if (o_m0_rd_data !== 32'hDEADBEEF || o_m1_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL read_data: got rd0=%h rd1=%h expected deadbeef 00000000",
               o_m0_rd_data, o_m1_rd_data);
    end
    $display("txn m0 read addr=00000100 data=%h", o_m0_rd_data);
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if ({o_bus_en, o_m0_ack} !== 2'b00 || cnt != 3) begin
      n_fail++;
      $display("FAIL read_end: got bus_en=%b ack=%b busy_cycles=%0d expected 0 0 3",
               o_bus_en, o_m0_ack, cnt);
    end
  endtask

  task automatic test_round_robin;
    // Expected service order across two ties and the pending loser: m0,m1,m0,m1.
    int order [4] = '{0, 1, 0, 1};
    do_reset();
    set_m0(1'b1, 1'b0, 32'hA0, 32'h0, 4'hF);
    set_m1(1'b1, 1'b0, 32'hB0, 32'h0, 4'hF);
    for (int t = 0; t < 4; t++) begin
      if (t == 2) begin
        set_m0(1'b1, 1'b0, 32'hA0, 32'h0, 4'hF);
        set_m1(1'b1, 1'b0, 32'hB0, 32'h0, 4'hF);
      end
      i_ack = 1'b0;
      #1;
      n_checks++;
      if (o_bus_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle t=%0d: bus_en got %b expected 0", t, o_bus_en);
      end
      tick();
      i_ack = 1'b1;
      i_rd_data = 32'h10 + t;
      #1;
      n_checks++;
      if ({o_grant, o_addr, o_m0_ack, o_m1_ack} !==
          {1'(order[t]), (order[t] == 0) ? 32'hA0 : 32'hB0, (order[t] == 0), (order[t] == 1)}) begin
        n_fail++;
        $display("FAIL rr_grant t=%0d: got g=%b a=%h ack0=%b ack1=%b expected master %0d",
                 t, o_grant, o_addr, o_m0_ack, o_m1_ack, order[t]);
      end
      $display("txn rr m%0d addr=%h", o_grant, o_addr);
      tick();
      if (order[t] == 0) i_m0_bus_en = 1'b0;
      else               i_m1_bus_en = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_timeout;
    set_m1(1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'h3);
    i_rd_data = 32'hFFFFFFFF;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      #1;
      n_checks++;
      if ({o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en, o_grant} !==
          {1'b1, 1'b1, 32'hCAFEF00D, 32'h200, 4'h3, 1'b1}) begin
        n_fail++;
        $display("FAIL tmo_bus k=%0d: got en=%b we=%b wd=%h a=%h be=%h g=%b expected 1 1 cafef00d 00000200 3 1",
                 k, o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en, o_grant);
      end
      n_checks++;
      if ({o_m1_ack, o_m1_err, o_m0_ack, o_m0_err} !== ((k == TIMEOUT) ? 4'b1100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL tmo_resp k=%0d: got %b expected %b", k,
                 {o_m1_ack, o_m1_err, o_m0_ack, o_m0_err}, (k == TIMEOUT) ? 4'b1100 : 4'b0000);
      end
    end
    n_checks++;
    if (o_m1_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_rd_data: got %h expected 00000000", o_m1_rd_data);
    end
    $display("txn m1 write addr=00000200 timed out");
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if ({o_bus_en, o_m1_ack, o_grant} !== 3'b001) begin
      n_fail++;
      $display("FAIL tmo_end: got en=%b ack=%b g=%b expected 0 0 1", o_bus_en, o_m1_ack, o_grant);
    end
  endtask

  task automatic test_edge_ack;
    set_m0(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    i_rd_data = 32'h5A5A5A5A;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      i_ack = (k == TIMEOUT);
      #1;
      n_checks++;
      if ({o_m0_ack, o_m0_err} !== {(k == TIMEOUT), 1'b0}) begin
        n_fail++;
        $display("FAIL edge_ack k=%0d: got ack=%b err=%b expected %b 0", k, o_m0_ack, o_m0_err,
                 (k == TIMEOUT));
      end
    end
    n_checks++;
    if (o_m0_rd_data !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL edge_rd_data: got %h expected 5a5a5a5a", o_m0_rd_data);
    end
    $display("txn m0 read addr=00000300 data=%h (ack on last cycle)", o_m0_rd_data);
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back;
    set_m0(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    tick();
    i_ack = 1'b1;
    #1;
    n_checks++;
    if (o_m0_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_ack: got %b expected 1", o_m0_ack);
    end
    tick();
    i_ack = 1'b0;
    set_m0(1'b1, 1'b1, 32'h504, 32'h77, 4'h1);
    #1;
    n_checks++;
    if (o_bus_en !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: bus_en got %b expected 0", o_bus_en);
    end
    tick();
    n_checks++;
    if ({o_bus_en, o_grant, o_addr, o_wr_en} !== {1'b1, 1'b0, 32'h504, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second: got en=%b g=%b a=%h we=%b expected 1 0 00000504 1",
               o_bus_en, o_grant, o_addr, o_wr_en);
    end
    i_ack = 1'b1;
    $display("txn m0 back-to-back write addr=00000504");
    tick();
    clear_inputs();
  endtask

  task automatic test_protocol_drop;
    set_m0(1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    tick();
    i_m0_bus_en = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      i_ack = (k == 4);
      i_rd_data = 32'h600D;
      #1;
      n_checks++;
      if ({o_bus_en, o_m0_ack, o_m0_err} !== {1'b1, (k == 4), 1'b0}) begin
        n_fail++;
        $display("FAIL drop_k%0d: got en=%b ack=%b err=%b expected 1 %b 0",
                 k, o_bus_en, o_m0_ack, o_m0_err, (k == 4));
      end
    end
    $display("txn m0 dropped request, completed data=%h", o_m0_rd_data);
    tick();
    clear_inputs();
  endtask

  task automatic test_stray_ack;
    i_ack = 1'b1;
    i_rd_data = 32'hBAD0BAD0;
    #1;
    n_checks++;
    if ({o_bus_en, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err} !== 5'b0 ||
        o_m0_rd_data !== 32'h0 || o_m1_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL stray_ack: got ctrl=%b rd0=%h rd1=%h expected all zero",
               {o_bus_en, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, o_m0_rd_data, o_m1_rd_data);
    end
    tick();
    i_ack = 1'b0;
    set_m1(1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    #1;
    n_checks++;
    if (o_bus_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_state: bus_en got %b expected 0", o_bus_en);
    end
    tick();
    n_checks++;
    if ({o_bus_en, o_grant, o_m1_ack} !== 3'b110) begin
      n_fail++;
      $display("FAIL stray_regrant: got en=%b g=%b ack=%b expected 1 1 0", o_bus_en, o_grant, o_m1_ack);
    end
    i_ack = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy;
    set_m0(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    tick();
    n_checks++;
    if (o_bus_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstb_busy: bus_en got %b expected 1", o_bus_en);
    end
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    set_m1(1'b1, 1'b0, 32'h480, 32'h0, 4'hF);
    #1;
    n_checks++;
    if ({o_bus_en, o_m0_ack, o_m0_err, o_grant} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstb_abort: got en=%b ack=%b err=%b g=%b expected 0 0 0 0",
               o_bus_en, o_m0_ack, o_m0_err, o_grant);
    end
    tick();
    n_checks++;
    if ({o_bus_en, o_grant, o_addr} !== {1'b1, 1'b0, 32'h400}) begin
      n_fail++;
      $display("FAIL rstb_tie: got en=%b g=%b a=%h expected 1 0 00000400", o_bus_en, o_grant, o_addr);
    end
    do_reset();
  endtask

  task automatic test_random;
    bit          busy = 0;
    int          owner = 0, age = 0, last = 1, grant_m = 0;
    bit [1:0]    req = 2'b00, acked = 2'b00;
    bit          ack_in, done;
    logic [31:0] addr [2], wd [2], rd;
    logic        we [2];
    logic [3:0]  be [2];
    logic [69:0] exp_bus;
    logic [3:0]  exp_resp;
    logic [31:0] exp_rd;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(req[n] && !acked[n])) begin
          req[n]  = ($urandom_range(0, 2) == 0);
          addr[n] = $urandom;
          wd[n]   = $urandom;
          we[n]   = 1'($urandom_range(0, 1));
          be[n]   = 4'($urandom_range(0, 15));
        end
      end
      ack_in = ($urandom_range(0, 3) == 0);
      rd     = $urandom;
      set_m0(req[0], we[0], addr[0], wd[0], be[0]);
      set_m1(req[1], we[1], addr[1], wd[1], be[1]);
      i_ack = ack_in;
      i_rd_data = rd;
      #1;
      done     = busy && (ack_in || age == TIMEOUT);
      exp_bus  = busy ? {1'b1, we[owner], wd[owner], addr[owner], be[owner]} : 70'd0;
      exp_resp = {done && owner == 0, done && owner == 1,
                  done && !ack_in && owner == 0, done && !ack_in && owner == 1};
      n_checks++;
      if ({o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en} !== exp_bus) begin
        n_fail++;
        $display("FAIL rnd_bus c=%0d: got %h expected %h", c,
                 {o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en}, exp_bus);
      end
      n_checks++;
      if ({o_m0_ack, o_m1_ack, o_m0_err, o_m1_err} !== exp_resp) begin
        n_fail++;
        $display("FAIL rnd_resp c=%0d: got %b expected %b", c,
                 {o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, exp_resp);
      end
      n_checks++;
      if (o_grant !== 1'(grant_m)) begin
        n_fail++;
        $display("FAIL rnd_grant c=%0d: got %b expected %0d", c, o_grant, grant_m);
      end
      // Read data is defined for the non-granted master and at completion.
      for (int n = 0; n < 2; n++) begin
        if (busy && (owner != n || done)) begin
          exp_rd = (owner == n && ack_in) ? rd : 32'h0;
          n_checks++;
          if (((n == 0) ? o_m0_rd_data : o_m1_rd_data) !== exp_rd) begin
            n_fail++;
            $display("FAIL rnd_rd%0d c=%0d: got %h expected %h", n, c,
                     (n == 0) ? o_m0_rd_data : o_m1_rd_data, exp_rd);
          end
        end
      end
      if (done)
        $display("txn c=%0d m%0d %s addr=%h %s", c, owner, we[owner] ? "write" : "read",
                 addr[owner], ack_in ? "ack" : "timeout");
      acked = {done && owner == 1, done && owner == 0};
      if (busy) begin
        if (done) busy = 0;
        else      age++;
      end else if (req != 2'b00) begin
        owner   = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
        last    = owner;
        grant_m = owner;
        busy    = 1;
        age     = 1;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    i_rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_edge_ack();
    test_back_to_back();
    test_protocol_drop();
    test_stray_ack();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
